lock_sequencer: RTL and testbench
=================================

// Module: lock_sequencer
// PURPOSE
//   Keypad-driven controller that sequences the door lock actuator. Collects PIN digits, compares
//   them against a fixed code, then issues one-cycle unlock/lock command pulses to the lock
//   actuator (lock/unlock inputs, doorLocked feedback). Also runs auto-relock, an entry timeout,
//   and a failed-attempt lockout with alarm. Sits between the keypad decoder and the lock actuator.
// PARAMETERS
//   PIN_LEN        4        number of digits per code (1..8)
//   PIN_CODE       16'h1234 BCD code, digit 0 (first entered) in MS nibble; width 4*PIN_LEN
//   MAX_FAIL       3        consecutive mismatches that trigger lockout (1..15)
//   RELOCK_CYCLES  1000     cycles door stays unlocked before automatic relock
//   ENTRY_TIMEOUT  500      idle cycles between digits before partial entry is discarded
//   LOCKOUT_CYCLES 5000     cycles spent in lockout
// PORTS
//   clk            in   1          system clock, all logic on rising edge
//   rst_n          in   1          asynchronous active-low reset
//   key_valid      in   1          one-cycle strobe, key_digit valid
//   key_digit      in   4          BCD digit 0..9; values 10..15 are ignored (strobe dropped)
//   lock_req       in   1          manual lock button, level, sampled each cycle
//   door_locked    in   1          actuator status (doorLocked), informational + relock check
//   lock           out  1          one-cycle lock command to actuator
//   unlock         out  1          one-cycle unlock command to actuator
//   alarm          out  1          high for whole lockout period
//   fail_cnt       out  4          current consecutive-mismatch count
//   state_o        out  3          encoded FSM state for debug/display
// BEHAVIOUR
//   Reset: FSM=IDLE, lock=0, unlock=0, alarm=0, fail_cnt=0, digit buffer/counters cleared.
//   States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
//   IDLE: valid digit -> store as digit 0, digit_cnt=1, -> ENTRY (-> CHECK directly if PIN_LEN=1).
//   ENTRY: each valid digit shifts in; idle timer reset on every accepted digit. When digit_cnt
//     reaches PIN_LEN -> CHECK next cycle. Idle timer hits ENTRY_TIMEOUT -> clear buffer, IDLE;
//     timeout does not count as a failure.
//   CHECK (exactly 1 cycle, keys ignored): match -> unlock=1 this cycle, fail_cnt=0, -> OPEN.
//     Mismatch -> fail_cnt+1; if new count==MAX_FAIL -> LOCKOUT (alarm=1 from next cycle),
//     else -> IDLE. Latency last digit strobe -> unlock pulse = 1 cycle.
//   OPEN: relock timer counts from 0. lock_req=1 or timer==RELOCK_CYCLES-1 -> lock=1 for one
//     cycle, -> IDLE. Keys ignored in OPEN. lock_req and timer expiry together -> single pulse.
//   LOCKOUT: alarm=1, all keys and lock_req ignored; after LOCKOUT_CYCLES -> IDLE, alarm=0,
//     fail_cnt=0.
//   lock_req in IDLE/ENTRY/CHECK: lock=1 one cycle only if door_locked==0 (recovers a door left
//     open); partial entry is preserved.
//   lock and unlock are never high in the same cycle; each is high at most one cycle per event.
//   Counters saturate; sized with $clog2 of their parameter +1. Invalid digits (>9) never change state.
//   Reset asserted mid-operation: outputs drop asynchronously to reset values; pending pulses lost.
// STRUCTURE
//   Shared package lock_pkg: state encoding localparams (IDLE=0..LOCKOUT=4), BCD digit width
//   constant, DIGIT_MAX=9.
//   One sub-module: lock_timer (load/enable/expire down-counter, param WIDTH), instantiated
//   once and shared by entry-timeout, relock and lockout (only one active per state).
//   Digit shift register and comparator inline.
// TESTING  (small params: RELOCK=20, TIMEOUT=10, LOCKOUT=30, MAX_FAIL=3, code 1234)
//   Reset: rst_n low mid-OPEN -> lock/unlock/alarm=0, state_o=IDLE immediately, fail_cnt=0.
//   Keys 1,2,3,4 -> unlock high exactly 1 cycle after digit 4 strobe; 20 cycles later lock pulse.
//   Keys 1,2,3,4 then lock_req at OPEN cycle 5 -> lock pulse that cycle, no second pulse at cycle 20.
//   Wrong code 1,2,3,5 x3 -> fail_cnt 1,2,3; alarm high 30 cycles; keys ignored; then fail_cnt=0.
//   Keys 1,2 then 10 idle cycles -> IDLE, fail_cnt unchanged; then 1,2,3,4 -> unlock.
//   Digit 4'hC and strobes during CHECK/OPEN -> no state change; lock/unlock never coincident.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock sequencer: state encoding,
// BCD digit limits and a small constant helper.
package lock_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_ENTRY   = 3'd1;
    localparam logic [2:0] ENC_CHECK   = 3'd2;
    localparam logic [2:0] ENC_OPEN    = 3'd3;
    localparam logic [2:0] ENC_LOCKOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_ENTRY   = ENC_ENTRY,
        ST_CHECK   = ENC_CHECK,
        ST_OPEN    = ENC_OPEN,
        ST_LOCKOUT = ENC_LOCKOUT
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable saturating down-counter; expire is high while the count sits at zero.
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_r;

    // Count down from the loaded value, holding at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lock_sequencer.sv
// Keypad PIN entry, code check and lock actuator sequencing with auto-relock,
// entry timeout and failed-attempt lockout.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                   PIN_LEN        = 4,
    parameter logic [4*PIN_LEN-1:0] PIN_CODE       = 16'h1234,
    parameter int                   MAX_FAIL       = 3,
    parameter int                   RELOCK_CYCLES  = 1000,
    parameter int                   ENTRY_TIMEOUT  = 500,
    parameter int                   LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       lock_req,
    input  logic       door_locked,
    output logic       lock,
    output logic       unlock,
    output logic       alarm,
    output logic [3:0] fail_cnt,
    output logic [2:0] state_o
);

    localparam int CODE_W  = DIGIT_W * PIN_LEN;
    localparam int CNT_W   = $clog2(PIN_LEN) + 1;
    localparam int TMR_W   = $clog2(max3(RELOCK_CYCLES, ENTRY_TIMEOUT, LOCKOUT_CYCLES)) + 1;
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(ENTRY_TIMEOUT - 1);
    // Relock interval is loaded on entry to CHECK so the lock pulse lands
    // exactly RELOCK_CYCLES after the unlock pulse.
    localparam logic [TMR_W-1:0] RELOCK_LOAD  = TMR_W'(RELOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       MAX_FAIL_C   = 4'(MAX_FAIL);

    state_e            state_r;
    logic [CODE_W-1:0] buf_r;
    logic [CNT_W-1:0]  digit_cnt_r;
    logic [3:0]        fail_cnt_r;
    logic              match_r;
    logic              lock_r;
    logic              unlock_r;
    logic              alarm_r;
    logic              lock_req_q_r;

    logic              digit_ok_s;
    logic              accept_s;
    logic              press_s;
    logic [CODE_W-1:0] next_buf_s;
    logic [CNT_W-1:0]  next_cnt_s;
    logic              last_digit_s;
    logic              match_s;
    logic [3:0]        fail_inc_s;
    logic              tmr_load_s;
    logic              tmr_en_s;
    logic [TMR_W-1:0]  tmr_load_val_s;
    logic              tmr_expire_s;

    assign digit_ok_s   = key_valid && (key_digit <= DIGIT_MAX);
    assign accept_s     = digit_ok_s && ((state_r == ST_IDLE) || (state_r == ST_ENTRY));
    assign press_s      = lock_req && !lock_req_q_r;
    assign next_buf_s   = (buf_r << DIGIT_W) | CODE_W'(key_digit);
    assign next_cnt_s   = digit_cnt_r + CNT_W'(1);
    assign last_digit_s = (next_cnt_s == CNT_W'(PIN_LEN));
    assign match_s      = (next_buf_s == PIN_CODE);
    assign fail_inc_s   = (fail_cnt_r == 4'hF) ? 4'hF : (fail_cnt_r + 4'd1);

    // Pick which interval the shared timer measures in the current state
    always_comb begin
        tmr_load_s     = 1'b0;
        tmr_en_s       = 1'b0;
        tmr_load_val_s = {TMR_W{1'b0}};
        case (state_r)
            ST_IDLE, ST_ENTRY: begin
                tmr_en_s = (state_r == ST_ENTRY);
                if (accept_s) begin
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = last_digit_s ? RELOCK_LOAD : TIMEOUT_LOAD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_CHECK: begin
                tmr_en_s = 1'b1;
                if (!match_r && (fail_inc_s == MAX_FAIL_C)) begin
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = LOCKOUT_LOAD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_OPEN, ST_LOCKOUT: tmr_en_s = 1'b1;
            default:             tmr_en_s = 1'b0;
        endcase
    end

    lock_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .en       (tmr_en_s),
        .load_val (tmr_load_val_s),
        .expire   (tmr_expire_s)
    );

    // Main sequencer: digit collection, code check, open/relock and lockout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            buf_r        <= {CODE_W{1'b0}};
            digit_cnt_r  <= {CNT_W{1'b0}};
            fail_cnt_r   <= 4'd0;
            match_r      <= 1'b0;
            lock_r       <= 1'b0;
            unlock_r     <= 1'b0;
            alarm_r      <= 1'b0;
            lock_req_q_r <= 1'b0;
        end else begin
            lock_r       <= 1'b0;
            unlock_r     <= 1'b0;
            lock_req_q_r <= lock_req;
            case (state_r)
                ST_IDLE, ST_ENTRY: begin
                    if (accept_s) begin
                        buf_r       <= next_buf_s;
                        digit_cnt_r <= next_cnt_s;
                        if (last_digit_s) begin
                            state_r  <= ST_CHECK;
                            match_r  <= match_s;
                            unlock_r <= match_s;
                        end else begin
                            state_r <= ST_ENTRY;
                        end
                    end else if ((state_r == ST_ENTRY) && tmr_expire_s) begin
                        buf_r       <= {CODE_W{1'b0}};
                        digit_cnt_r <= {CNT_W{1'b0}};
                        state_r     <= ST_IDLE;
                    end
                    // A manual lock never shares a cycle with an unlock pulse
                    lock_r <= press_s && !door_locked && !(accept_s && last_digit_s && match_s);
                end
                ST_CHECK: begin
                    buf_r       <= {CODE_W{1'b0}};
                    digit_cnt_r <= {CNT_W{1'b0}};
                    if (match_r) begin
                        fail_cnt_r <= 4'd0;
                        state_r    <= ST_OPEN;
                    end else begin
                        fail_cnt_r <= fail_inc_s;
                        lock_r     <= press_s && !door_locked;
                        if (fail_inc_s == MAX_FAIL_C) begin
                            state_r <= ST_LOCKOUT;
                            alarm_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_OPEN: begin
                    if (lock_req || tmr_expire_s) begin
                        lock_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_expire_s) begin
                        alarm_r    <= 1'b0;
                        fail_cnt_r <= 4'd0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    buf_r       <= {CODE_W{1'b0}};
                    digit_cnt_r <= {CNT_W{1'b0}};
                    alarm_r     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign lock     = lock_r;
    assign unlock   = unlock_r;
    assign alarm    = alarm_r;
    assign fail_cnt = fail_cnt_r;
    assign state_o  = state_r;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the lock rules.
module tb_lock_sequencer;

    localparam int PIN_LEN = 4;
    localparam int MAX_FAIL = 3;
    localparam int RELOCK = 20;
    localparam int TIMEOUT = 10;
    localparam int LOCKOUT = 30;
    localparam int P_IDLE = 0, P_ENTRY = 1, P_CHECK = 2, P_OPEN = 3, P_LOCKOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       lock_req;
    logic       door_locked;
    logic       lock;
    logic       unlock;
    logic       alarm;
    logic [3:0] fail_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    // behavioural model: phase, entered digits, ages since relevant events
    int m_phase, m_fail, m_idle, m_age, m_lo;
    bit m_match, m_prev;
    int m_digits[$];
    bit e_lock, e_unlock, e_alarm;
    int code_d[4] = '{1, 2, 3, 4};

    lock_sequencer #(
        .PIN_LEN(4), .PIN_CODE(16'h1234), .MAX_FAIL(3),
        .RELOCK_CYCLES(20), .ENTRY_TIMEOUT(10), .LOCKOUT_CYCLES(30)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
        .lock_req(lock_req), .door_locked(door_locked), .lock(lock), .unlock(unlock),
        .alarm(alarm), .fail_cnt(fail_cnt), .state_o(state_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = P_IDLE; m_fail = 0; m_idle = 0; m_age = 0; m_lo = 0;
        m_match = 1'b0; m_prev = 1'b0; m_digits.delete();
        e_lock = 1'b0; e_unlock = 1'b0; e_alarm = 1'b0;
    endfunction

    function automatic void model_step(bit kv, int kd, bit req, bit door);
        bit press;
        press = req && !m_prev;
        m_prev = req;
        e_lock = 1'b0;
        e_unlock = 1'b0;
        case (m_phase)
            P_IDLE, P_ENTRY: begin
                if (kv && kd <= 9) begin
                    m_digits.push_back(kd);
                    m_idle = 0;
                    if (m_digits.size() == PIN_LEN) begin
                        m_match = 1'b1;
                        foreach (m_digits[i]) if (m_digits[i] != code_d[i]) m_match = 1'b0;
                        e_unlock = m_match;
                        m_phase = P_CHECK;
                    end else begin
                        m_phase = P_ENTRY;
                    end
                end else if (m_phase == P_ENTRY) begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_digits.delete();
                        m_phase = P_IDLE;
                    end
                end
                e_lock = press && !door && !e_unlock;
            end
            P_CHECK: begin
                m_digits.delete();
                if (m_match) begin
                    m_fail = 0;
                    m_phase = P_OPEN;
                    m_age = 1;
                end else begin
                    m_fail++;
                    e_lock = press && !door;
                    if (m_fail == MAX_FAIL) begin
                        m_phase = P_LOCKOUT;
                        e_alarm = 1'b1;
                        m_lo = 1;
                    end else begin
                        m_phase = P_IDLE;
                    end
                end
            end
            P_OPEN: begin
                m_age++;
                if (req || m_age == RELOCK) begin
                    e_lock = 1'b1;
                    m_phase = P_IDLE;
                end
            end
            default: begin
                if (m_lo == LOCKOUT) begin
                    m_phase = P_IDLE;
                    e_alarm = 1'b0;
                    m_fail = 0;
                end else begin
                    m_lo++;
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(key_valid, int'(key_digit), lock_req, door_locked);
        #1;
        chk("lock", lock, e_lock);
        chk("unlock", unlock, e_unlock);
        chk("alarm", alarm, e_alarm);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("state", state_o, m_phase);
        chk("lock_unlock_excl", lock & unlock, 0);
        if (e_lock) door_locked = 1'b1;
        else if (e_unlock) door_locked = 1'b0;
    endtask

    task automatic send_digit(input int d);
        key_valid = 1'b1; key_digit = 4'(d); tick();
        key_valid = 1'b0; tick();
    endtask

    task automatic send_code(input int a, input int b, input int c, input int d);
        send_digit(a); send_digit(b); send_digit(c);
        key_valid = 1'b1; key_digit = 4'(d); tick();
        key_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_unlock"}, unlock, 0);
        chk({tag, "_alarm"}, alarm, 0);
        chk({tag, "_fail"}, fail_cnt, 0);
        chk({tag, "_state"}, state_o, P_IDLE);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n_lock, lock_at, n_alarm, p, ptr;
        rst_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0; lock_req = 1'b0; door_locked = 1'b1;
        model_reset();
        #2;
        chk("rst_lock", lock, 0);
        chk("rst_unlock", unlock, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_state", state_o, P_IDLE);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // correct code, then automatic relock RELOCK cycles after the unlock pulse
        send_code(1, 2, 3, 4);
        chk("d4_unlock", unlock, 1);
        chk("d4_state", state_o, P_CHECK);
        n_lock = 0; lock_at = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (lock) begin
                n_lock++;
                if (lock_at == 0) lock_at = i;
            end
        end
        chk("relock_at", lock_at, RELOCK);
        chk("relock_pulses", n_lock, 1);

        // manual lock in OPEN gives one pulse and no later relock pulse
        send_code(1, 2, 3, 4);
        repeat (5) tick();
        lock_req = 1'b1; tick();
        chk("manual_lock", lock, 1);
        lock_req = 1'b0;
        n_lock = 0;
        repeat (25) begin tick(); n_lock += int'(lock); end
        chk("no_second_lock", n_lock, 0);

        // three wrong codes: fail count climbs, lockout ignores keys and lock_req
        for (int k = 1; k <= 3; k++) begin
            send_code(1, 2, 3, 5);
            tick();
            chk("fail_step", fail_cnt, k);
        end
        chk("alarm_on", alarm, 1);
        n_alarm = 1;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) begin
                key_valid = 1'b1; key_digit = 4'($urandom_range(0, 9)); lock_req = i[0];
            end else begin
                key_valid = 1'b0; lock_req = 1'b0;
            end
            tick();
            n_alarm += int'(alarm);
        end
        chk("lockout_len", n_alarm, LOCKOUT);
        chk("fail_after_lockout", fail_cnt, 0);
        chk("state_after_lockout", state_o, P_IDLE);

        // partial entry times out without counting as a failure
        send_code(1, 2, 3, 5);
        tick();
        chk("fail_before_timeout", fail_cnt, 1);
        send_digit(1); send_digit(2);
        repeat (8) tick();
        chk("pre_timeout_state", state_o, P_ENTRY);
        tick();
        chk("timeout_state", state_o, P_IDLE);
        chk("timeout_fail", fail_cnt, 1);
        send_code(1, 2, 3, 4);
        chk("after_timeout_unlock", unlock, 1);
        tick();
        chk("match_clears_fail", fail_cnt, 0);
        lock_req = 1'b1; tick(); lock_req = 1'b0;
        chk("manual_lock2", lock, 1);

        // invalid digits and strobes during CHECK/OPEN change nothing
        key_valid = 1'b1; key_digit = 4'hC; tick(); key_valid = 1'b0;
        chk("bad_digit_idle", state_o, P_IDLE);
        send_digit(1);
        key_valid = 1'b1; key_digit = 4'hF; tick(); key_valid = 1'b0;
        chk("bad_digit_entry", state_o, P_ENTRY);
        send_digit(2); send_digit(3);
        key_valid = 1'b1; key_digit = 4'd4; tick();
        chk("unlock_despite_bad", unlock, 1);
        key_digit = 4'd9; tick();
        repeat (4) begin key_digit = 4'($urandom_range(0, 9)); tick(); end
        chk("open_ignores_keys", state_o, P_OPEN);
        key_valid = 1'b0;
        lock_req = 1'b1; tick(); lock_req = 1'b0; tick();

        // asynchronous reset during CHECK, OPEN and LOCKOUT
        send_code(1, 2, 3, 5); tick();
        send_code(1, 2, 3, 4);
        chk("pre_rst_unlock", unlock, 1);
        chk("pre_rst_fail", fail_cnt, 1);
        do_reset("rst_check");
        send_code(1, 2, 3, 4);
        repeat (3) tick();
        do_reset("rst_open");
        for (int k = 0; k < 3; k++) begin send_code(4, 3, 2, 1); tick(); end
        chk("pre_rst_alarm", alarm, 1);
        do_reset("rst_lockout");

        // randomized traffic against the model
        ptr = 0;
        for (int seg = 0; seg < 15; seg++) begin
            p = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 35 : 75);
            for (int i = 0; i < 200; i++) begin
                key_valid = ($urandom_range(0, 99) < p);
                if ($urandom_range(0, 3) == 0) begin
                    key_digit = 4'($urandom_range(0, 15));
                end else begin
                    key_digit = 4'(ptr + 1);
                    ptr = (ptr + 1) % 4;
                end
                if ($urandom_range(0, 15) == 0) lock_req = ~lock_req;
                if ($urandom_range(0, 19) == 0) door_locked = ~door_locked;
                tick();
            end
        end
        key_valid = 1'b0; lock_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
